// File: rtl/mm_pkg.sv
// Shared defaults for the matrix-multiply datapath blocks.
package mm_pkg;
    localparam int DEFAULT_N    = 4;
    localparam int DEFAULT_W    = 32;
    localparam int DESKEW_DEPTH = 4;
endpackage

// File: rtl/nRegisterChain.sv
// Fixed-length unreset register chain: q is d delayed by N cycles.
module nRegisterChain #(
    parameter int N = 1,
    parameter int W = 8
) (
    input  logic         clk,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    logic [W-1:0] stage [N];

    always_ff @(posedge clk) begin
        stage[0] <= d;
        for (int k = 1; k < N; k++) begin
            stage[k] <= stage[k-1];
        end
    end

    assign q = stage[N-1];
endmodule

// File: rtl/row_deskew.sv
// Realigns skewed systolic lanes into whole rows and buffers them in a FIFO.
// Define DESKEW_ROWCOUNT_EN to add the row_count transfer counter port.
module row_deskew
    import mm_pkg::*;
#(
    parameter int N     = DEFAULT_N,
    parameter int W     = DEFAULT_W,
    parameter int DEPTH = DESKEW_DEPTH
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    input  logic [N*W-1:0] in_data,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [N*W-1:0] out_data,
    output logic           overflow
`ifdef DESKEW_ROWCOUNT_EN
    ,
    output logic [31:0]    row_count
`endif
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [N*W-1:0] aligned;
    logic           push;

    // Lane i lags lane 0 by i cycles, so it needs N-1-i more to line up.
    for (genvar i = 0; i < N - 1; i++) begin : g_lane
        nRegisterChain #(
            .N(N - 1 - i),
            .W(W)
        ) u_chain (
            .clk(clk),
            .d  (in_data[i*W +: W]),
            .q  (aligned[i*W +: W])
        );
    end
    assign aligned[(N-1)*W +: W] = in_data[(N-1)*W +: W];

    if (N > 1) begin : g_vpipe
        logic [N-2:0] vp;
        always_ff @(posedge clk) begin
            if (rst) begin
                vp <= '0;
            end else begin
                vp[0] <= in_valid;
                for (int k = 1; k < N - 1; k++) begin
                    vp[k] <= vp[k-1];
                end
            end
        end
        assign push = vp[N-2];
    end else begin : g_novpipe
        assign push = in_valid;
    end

    logic [N*W-1:0] mem [DEPTH];
    logic [PW-1:0]  wr_ptr;
    logic [PW-1:0]  rd_ptr;
    logic           empty;
    logic           full;
    logic           pop;
    logic           wr_en;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign out_valid = !empty;
    assign pop       = out_valid && out_ready;
    // A pop in the same cycle frees the slot the push needs.
    assign wr_en     = push && (!full || pop);

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr[AW-1:0]] <= aligned;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (push && full && !pop) begin
                overflow <= 1'b1;
            end
        end
    end

    // Memory is unreset, so mask the head while nothing is buffered.
    assign out_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

`ifdef DESKEW_ROWCOUNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            row_count <= '0;
        end else if (pop) begin
            row_count <= row_count + 32'd1;
        end
    end
`endif
endmodule
